mon_comb_readout: RTL and testbench

- Head-of-chain consumer for a daisy chain of double-integrator/serializer monitor channels.
- Generates the periodic `samp` strobe for the chain.
- Captures the serialized per-channel integrator words and applies the second-order CIC comb (double difference) per channel.
- Pushes scaled, saturated results with a channel tag into an output FIFO for host/DSP readout over valid/ready.

---
 rtl/mon_pkg.sv | 26 ++
 rtl/mon_fifo.sv | 47 ++++
 rtl/mon_comb_readout.sv | 147 ++++++++++++++
 tb/tb_mon_comb_readout.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mon_pkg.sv
// Shared constants and helpers for the monitor readout chain.
package mon_pkg;
  localparam int DEF_RWI = 28;
  localparam int DEF_OWI = 20;
  localparam int DEF_NCH = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Clamp a signed value into the range of a w-bit two's complement word.
  function automatic logic signed [63:0] sat_s(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction
endpackage

// File: rtl/mon_fifo.sv
// First-word-fall-through FIFO; a push into a full FIFO is refused unless a pop frees a slot.
module mon_fifo
  import mon_pkg::*;
#(
  parameter int W     = 22,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_valid,
  output logic         o_full
);
  localparam int AW = clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_empty;
  logic         w_pop;
  logic         w_push;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign w_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop   = i_pop && !w_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_valid = !w_empty;
  assign o_data  = w_empty ? '0 : r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + (AW + 1)'(1);
      if (w_pop)  r_rd <= r_rd + (AW + 1)'(1);
    end
  end
endmodule

// File: rtl/mon_comb_readout.sv
// Head-of-chain readout: issues samp, captures per-channel integrator words,
// applies the second-order comb, scales/saturates and queues tagged results.
module mon_comb_readout
  import mon_pkg::*;
#(
  parameter int rwi    = DEF_RWI,
  parameter int owi    = DEF_OWI,
  parameter int nch    = DEF_NCH,
  parameter int shift  = 8,
  parameter int fdepth = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic [15:0]           period,
  output logic                  samp,
  input  logic signed [rwi-1:0] s_in,
  input  logic                  g_in,
  output logic signed [owi-1:0] out_data,
  output logic [clog2(nch)-1:0] out_chan,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  overflow,
  output logic                  frame_err,
  input  logic                  clr_err
);
  localparam int CW = clog2(nch);
  localparam int KW = clog2(nch + 1);

  logic [15:0]           w_per;
  logic [15:0]           r_cnt;
  logic [KW-1:0]         r_k;
  logic                  r_gPrev;
  logic [1:0]            r_prime;
  logic signed [rwi-1:0] r_xPrev  [nch];
  logic signed [rwi-1:0] r_d1Prev [nch];
  logic                  r_s1Valid;
  logic [CW-1:0]         r_s1Chan;
  logic signed [rwi-1:0] r_s1D2;
  logic                  r_s2Valid;
  logic [CW-1:0]         r_s2Chan;
  logic signed [owi-1:0] r_s2Data;
  logic                  w_frameEnd;
  logic                  w_accept;
  logic [CW-1:0]         w_idx;
  logic signed [rwi-1:0] w_d1;
  logic signed [rwi-1:0] w_d2;
  logic signed [63:0]    w_ext;
  logic signed [63:0]    w_scaled;
  logic                  w_errSet;
  logic                  w_full;
  logic                  w_drop;
  logic [owi+CW-1:0]     w_fifoOut;

  assign w_per = (period < 16'd2) ? 16'd2 : period;
  assign samp  = enable && (r_cnt == w_per - 16'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       r_cnt <= '0;
    else if (!enable)                 r_cnt <= '0;
    else if (r_cnt >= w_per - 16'd1)  r_cnt <= '0;
    else                              r_cnt <= r_cnt + 16'd1;
  end

  assign w_frameEnd = r_gPrev && !g_in;
  assign w_accept   = g_in && (r_k < KW'(nch));
  assign w_idx      = r_k[CW-1:0];
  assign w_d1       = s_in - r_xPrev[w_idx];
  assign w_d2       = w_d1 - r_d1Prev[w_idx];
  assign w_errSet   = (g_in && !w_accept) || (w_frameEnd && (r_k != KW'(nch))) || (samp && g_in);

  // Comb stage; results are only forwarded once two frame ends have primed the history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= '0;
      r_gPrev   <= 1'b0;
      r_prime   <= '0;
      r_s1Valid <= 1'b0;
      r_s1Chan  <= '0;
      r_s1D2    <= '0;
      for (int i = 0; i < nch; i++) begin
        r_xPrev[i]  <= '0;
        r_d1Prev[i] <= '0;
      end
    end else begin
      r_gPrev   <= g_in;
      r_s1Valid <= w_accept && (r_prime == 2'd2);
      r_s1Chan  <= w_idx;
      r_s1D2    <= w_d2;
      if (w_accept) begin
        r_xPrev[w_idx]  <= s_in;
        r_d1Prev[w_idx] <= w_d1;
        r_k             <= r_k + KW'(1);
      end else if (w_frameEnd) begin
        r_k <= '0;
        if (r_prime != 2'd2) r_prime <= r_prime + 2'd1;
      end
    end
  end

  assign w_ext    = {{(64 - rwi){r_s1D2[rwi-1]}}, r_s1D2};
  assign w_scaled = w_ext >>> shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2Valid <= 1'b0;
      r_s2Chan  <= '0;
      r_s2Data  <= '0;
    end else begin
      r_s2Valid <= r_s1Valid;
      r_s2Chan  <= r_s1Chan;
      r_s2Data  <= owi'(sat_s(w_scaled, owi));
    end
  end

  mon_fifo #(
    .W    (owi + CW),
    .DEPTH(fdepth)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_s2Valid),
    .i_data ({r_s2Chan, r_s2Data}),
    .i_pop  (out_ready),
    .o_data (w_fifoOut),
    .o_valid(out_valid),
    .o_full (w_full)
  );

  assign out_chan = w_fifoOut[owi+CW-1:owi];
  assign out_data = w_fifoOut[owi-1:0];
  assign w_drop   = r_s2Valid && w_full && !(out_ready && out_valid);

  // A clear in the same cycle as a new error wins; that error is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (clr_err) begin
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (w_drop)   overflow  <= 1'b1;
      if (w_errSet) frame_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mon_comb_readout.sv
// Directed self-checking bench for mon_comb_readout (nch=2, shift=0 build).
module tb_mon_comb_readout;
  localparam int RWI = 28;
  localparam int OWI = 20;
  localparam int NCH = 2;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  enable;
  logic [15:0]           period;
  logic                  samp;
  logic signed [RWI-1:0] s_in;
  logic                  g_in;
  logic signed [OWI-1:0] out_data;
  logic [0:0]            out_chan;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overflow;
  logic                  frame_err;
  logic                  clr_err;
  int                    checks   = 0;
  int                    failures = 0;
  int                    pulses;

  always #5 clk = ~clk;

  mon_comb_readout #(
    .rwi(RWI), .owi(OWI), .nch(NCH), .shift(0), .fdepth(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .period(period), .samp(samp),
    .s_in(s_in), .g_in(g_in), .out_data(out_data), .out_chan(out_chan),
    .out_valid(out_valid), .out_ready(out_ready), .overflow(overflow),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0; g_in = 1'b0; s_in = '0; enable = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic applyStimulus(input int x0, input int x1);
    g_in = 1'b1; s_in = x0[RWI-1:0];
    step();
    s_in = x1[RWI-1:0];
    step();
    g_in = 1'b0; s_in = '0;
    step();
  endtask

  task automatic popWord(input string tag, input int ch, input int d);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_chan"}, 32'(out_chan), ch);
    checkOutput({tag, "_data"}, 32'(out_data), d);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    period = 16'd20;
    rst_n = 1'b0; g_in = 1'b0; s_in = '0; enable = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    step(); step();
    checkOutput("rst_samp", 32'(samp), 32'd0);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_data", 32'(out_data), 32'd0);
    checkOutput("rst_chan", 32'(out_chan), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_ferr", 32'(frame_err), 32'd0);
    rst_n = 1'b1;
    step();

    $display("[TB] strobe timing");
    enable = 1'b1;
    for (int i = 1; i <= 59; i++) begin
      step();
      checkOutput("samp_run", 32'(samp), 32'(i % 20 == 19));
    end
    enable = 1'b0;
    #1;
    checkOutput("samp_gated", 32'(samp), 32'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (samp) pulses++;
    end
    checkOutput("samp_disabled", pulses, 32'd0);
    enable = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checkOutput("samp_restart", 32'(samp), 32'(i == 19));
    end
    enable = 1'b0;
    step();
    period = 16'd1;
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      checkOutput("samp_min_period", 32'(samp), 32'(i % 2 == 1));
    end
    enable = 1'b0;
    period = 16'd20;

    $display("[TB] quadratic input");
    doReset();
    applyStimulus(0, 0);
    applyStimulus(1, 3);
    step(); step();
    checkOutput("prime_none", 32'(out_valid), 32'd0);
    g_in = 1'b1; s_in = 28'sd4;
    step();
    checkOutput("lat_t1", 32'(out_valid), 32'd0);
    s_in = 28'sd12;
    step();
    checkOutput("lat_t2", 32'(out_valid), 32'd0);
    g_in = 1'b0; s_in = '0;
    step();
    checkOutput("lat_t3", 32'(out_valid), 32'd1);
    applyStimulus(9, 27);
    applyStimulus(16, 48);
    step(); step();
    for (int f = 2; f <= 4; f++) begin
      popWord("quad_ch0", 0, 2);
      popWord("quad_ch1", 1, 6);
    end
    checkOutput("quad_empty", 32'(out_valid), 32'd0);
    checkOutput("quad_ovf", 32'(overflow), 32'd0);
    checkOutput("quad_ferr", 32'(frame_err), 32'd0);

    $display("[TB] wrap and saturation");
    doReset();
    applyStimulus(134217726, 0);
    applyStimulus(134217727, 0);
    applyStimulus(-134217728, 2097152);
    applyStimulus(-134217727, 2097152);
    step(); step();
    popWord("wrap0", 0, 0);
    popWord("sat_pos", 1, 524287);
    popWord("wrap1", 0, 0);
    popWord("sat_neg", 1, -524288);

    $display("[TB] backpressure");
    doReset();
    for (int f = 0; f <= 11; f++) applyStimulus(f * f * f, 2 * f * f * f);
    step(); step();
    checkOutput("bp_ovf", 32'(overflow), 32'd1);
    checkOutput("bp_ferr", 32'(frame_err), 32'd0);
    for (int f = 2; f <= 9; f++) begin
      popWord("bp_ch0", 0, 6 * (f - 1));
      popWord("bp_ch1", 1, 12 * (f - 1));
    end
    checkOutput("bp_empty", 32'(out_valid), 32'd0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checkOutput("bp_clr", 32'(overflow), 32'd0);

    $display("[TB] frame errors");
    doReset();
    g_in = 1'b1; s_in = 28'sd5;
    step();
    s_in = 28'sd7;
    step();
    checkOutput("long_ok", 32'(frame_err), 32'd0);
    s_in = 28'sd100;
    step();
    checkOutput("long_err", 32'(frame_err), 32'd1);
    g_in = 1'b0; s_in = '0; clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    checkOutput("long_clr", 32'(frame_err), 32'd0);
    applyStimulus(5, 7);
    checkOutput("good_frame", 32'(frame_err), 32'd0);
    applyStimulus(5, 7);
    step(); step();
    popWord("long_ch0", 0, 0);
    popWord("long_ch1", 1, 0);
    g_in = 1'b1; s_in = 28'sd5;
    step();
    g_in = 1'b0; s_in = '0;
    step();
    checkOutput("short_err", 32'(frame_err), 32'd1);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    applyStimulus(5, 7);
    step(); step();
    popWord("short_ch0", 0, 0);
    popWord("short_ch0b", 0, 0);
    popWord("short_ch1", 1, 0);
    checkOutput("short_empty", 32'(out_valid), 32'd0);
    period = 16'd2; enable = 1'b1; g_in = 1'b1;
    step();
    checkOutput("samp_gate_pre", 32'(frame_err), 32'd0);
    step();
    checkOutput("samp_gate_err", 32'(frame_err), 32'd1);
    g_in = 1'b0; enable = 1'b0; period = 16'd20;

    $display("[TB] reset mid-frame");
    doReset();
    applyStimulus(0, 0);
    applyStimulus(1, 3);
    applyStimulus(4, 12);
    step(); step();
    checkOutput("mid_pre_valid", 32'(out_valid), 32'd1);
    g_in = 1'b1; s_in = 28'sd9;
    step();
    s_in = 28'sd27;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_valid", 32'(out_valid), 32'd0);
    checkOutput("mid_data", 32'(out_data), 32'd0);
    checkOutput("mid_chan", 32'(out_chan), 32'd0);
    checkOutput("mid_samp", 32'(samp), 32'd0);
    checkOutput("mid_ovf", 32'(overflow), 32'd0);
    checkOutput("mid_ferr", 32'(frame_err), 32'd0);
    g_in = 1'b0; s_in = '0;
    step();
    rst_n = 1'b1;
    step();
    applyStimulus(0, 0);
    step(); step();
    checkOutput("reprime0", 32'(out_valid), 32'd0);
    applyStimulus(1, 3);
    step(); step();
    checkOutput("reprime1", 32'(out_valid), 32'd0);
    applyStimulus(4, 12);
    step(); step();
    popWord("reprime_ch0", 0, 2);
    popWord("reprime_ch1", 1, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
